// File: rtl/ins_stream_driver.sv
// Loadable instruction source for the 16-bit cpu core: it issues program words on a timer or on cpu request edges.
// Optional macro STALL_TIMEOUT_EN adds a handshake stall watchdog that drives err.
module ins_stream_driver #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int HOLD_CYCLES = 40,
    parameter int LOOP        = 0,
    parameter int TIMEOUT     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              mode,
    input  logic              start,
    input  logic              stop,
    input  logic              cpu_req,
    output logic [DATA_W-1:0] ins,
    output logic              en_in,
    output logic              en_ram_out,
    output logic [ADDR_W-1:0] ins_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ins, w_ins_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic              r_en, w_en_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_mode, w_mode_next;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic [HOLD_W-1:0] r_hold, w_hold_next;
    logic              r_req_prev;

    logic              w_wr_fire;
    logic              w_req_edge;
    logic              w_last;
    logic              w_hold_exp;
    logic              w_advance;
    logic              w_stall_abort;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [LEN_W-1:0]  w_len_clamp;

`ifdef STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] r_stall, w_stall_next;
    logic               r_err, w_err_next;
    assign w_stall_abort = r_err;
    assign err           = r_err;
`else
    assign w_stall_abort = 1'b0;
    assign err           = 1'b0;
`endif

    assign w_wr_fire   = wr_en && !r_busy && ({1'b0, wr_addr} < LEN_W'(DEPTH));
    assign w_req_edge  = cpu_req && !r_req_prev;
    assign w_last      = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
    assign w_hold_exp  = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
    assign w_advance   = r_mode ? w_req_edge : w_hold_exp;
    assign w_len_clamp = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;

    // The address of the word that becomes visible next: idx+1, or 0 on start/wrap.
    assign w_rd_addr = (r_state == ST_RUN && !w_last) ? (r_idx + ADDR_W'(1)) : '0;
    // A write landing in the same cycle as start must be seen by the first fetch.
    assign w_rd_data = (w_wr_fire && (wr_addr == w_rd_addr)) ? wr_data : r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ins_next   = r_ins;
        w_idx_next   = r_idx;
        w_en_next    = r_en;
        w_busy_next  = r_busy;
        w_done_next  = r_done;
        w_mode_next  = r_mode;
        w_len_next   = r_len;
        w_hold_next  = r_hold;
`ifdef STALL_TIMEOUT_EN
        w_stall_next = r_stall;
        w_err_next   = r_err;
`endif
        if (stop) begin
            w_state_next = ST_IDLE;
            w_ins_next   = '0;
            w_idx_next   = '0;
            w_en_next    = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b0;
            w_hold_next  = '0;
`ifdef STALL_TIMEOUT_EN
            w_stall_next = '0;
            w_err_next   = 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && (prog_len != '0)) begin
                        w_state_next = ST_RUN;
                        w_ins_next   = w_rd_data;
                        w_idx_next   = '0;
                        w_en_next    = 1'b1;
                        w_busy_next  = 1'b1;
                        w_done_next  = 1'b0;
                        w_mode_next  = mode;
                        w_len_next   = w_len_clamp;
                        w_hold_next  = '0;
`ifdef STALL_TIMEOUT_EN
                        w_stall_next = STALL_W'(1);
                        w_err_next   = 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (!r_mode) begin
                        w_hold_next = w_hold_exp ? '0 : (r_hold + HOLD_W'(1));
                    end
`ifdef STALL_TIMEOUT_EN
                    // r_stall counts the cycles the current word has waited for a request.
                    if (r_mode) begin
                        if (w_req_edge) begin
                            w_stall_next = STALL_W'(1);
                        end else if (r_stall == STALL_W'(TIMEOUT - 1)) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_stall_next = r_stall + STALL_W'(1);
                        end
                    end
`endif
                    if (w_stall_abort || (w_advance && w_last && (LOOP == 0))) begin
                        w_state_next = ST_DONE;
                        w_en_next    = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else if (w_advance) begin
                        w_idx_next = w_rd_addr;
                        w_ins_next = w_rd_data;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ins      <= '0;
            r_idx      <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_len      <= '0;
            r_hold     <= '0;
            r_req_prev <= 1'b0;
`ifdef STALL_TIMEOUT_EN
            r_stall    <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_ins      <= w_ins_next;
            r_idx      <= w_idx_next;
            r_en       <= w_en_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_mode     <= w_mode_next;
            r_len      <= w_len_next;
            r_hold     <= w_hold_next;
            r_req_prev <= cpu_req;
`ifdef STALL_TIMEOUT_EN
            r_stall    <= w_stall_next;
            r_err      <= w_err_next;
`endif
        end
    end

    assign ins        = r_ins;
    assign en_in      = r_en;
    assign en_ram_out = r_en;
    assign ins_idx    = r_idx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_ins_stream_driver.sv
// Scoreboard bench for ins_stream_driver: one stopping and one looping instance share stimulus,
// and per-instance monitors compare each newly presented word against queued expectations.
module tb_ins_stream_driver;
    logic        clk = 1'b0;
    logic        rst, wr_en, mode, start, stop, cpu_req;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  prog_len;

    logic [15:0] m_ins, l_ins;
    logic [2:0]  m_idx, l_idx;
    logic        m_en_in, m_en_ram_out, m_busy, m_done, m_err;
    logic        l_en_in, l_en_ram_out, l_busy, l_done, l_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] ins;
        int          cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_loop[$];
    exp_t e_main, e_loop;
    logic main_mon_en = 1'b0, loop_mon_en = 1'b0;
    logic m_prev_en = 1'b0, l_prev_en = 1'b0;
    logic [2:0] m_prev_idx = '0, l_prev_idx = '0;

    ins_stream_driver #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .HOLD_CYCLES(4), .LOOP(0), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .mode(mode), .start(start), .stop(stop), .cpu_req(cpu_req),
        .ins(m_ins), .en_in(m_en_in), .en_ram_out(m_en_ram_out), .ins_idx(m_idx),
        .busy(m_busy), .done(m_done), .err(m_err));

    ins_stream_driver #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .HOLD_CYCLES(4), .LOOP(1), .TIMEOUT(16)) u_loop (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .prog_len(prog_len), .mode(mode), .start(start), .stop(stop), .cpu_req(cpu_req),
        .ins(l_ins), .en_in(l_en_in), .en_ram_out(l_en_ram_out), .ins_idx(l_idx),
        .busy(l_busy), .done(l_done), .err(l_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // A new word is presented when en_ram_out rises or ins_idx changes while it is high.
    always @(negedge clk) begin
        if (main_mon_en && m_en_ram_out && (!m_prev_en || m_idx != m_prev_idx)) begin
            checks++;
            if (q_main.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_word actual idx=%0d ins=%h cyc=%0d required none", m_idx, m_ins, cyc);
            end else begin
                e_main = q_main.pop_front();
                if (m_idx !== e_main.idx || m_ins !== e_main.ins || cyc != e_main.cyc) begin
                    errors++;
                    $display("FAIL main_word actual idx=%0d ins=%h cyc=%0d required idx=%0d ins=%h cyc=%0d",
                             m_idx, m_ins, cyc, e_main.idx, e_main.ins, e_main.cyc);
                end
            end
        end
        m_prev_en  <= m_en_ram_out;
        m_prev_idx <= m_idx;
    end

    always @(negedge clk) begin
        if (loop_mon_en && l_en_ram_out && (!l_prev_en || l_idx != l_prev_idx)) begin
            checks++;
            if (q_loop.size() == 0) begin
                errors++;
                $display("FAIL loop_unexpected_word actual idx=%0d ins=%h cyc=%0d required none", l_idx, l_ins, cyc);
            end else begin
                e_loop = q_loop.pop_front();
                if (l_idx !== e_loop.idx || l_ins !== e_loop.ins || cyc != e_loop.cyc) begin
                    errors++;
                    $display("FAIL loop_word actual idx=%0d ins=%h cyc=%0d required idx=%0d ins=%h cyc=%0d",
                             l_idx, l_ins, cyc, e_loop.idx, e_loop.ins, e_loop.cyc);
                end
            end
        end
        l_prev_en  <= l_en_ram_out;
        l_prev_idx <= l_idx;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_main(input int idx, input logic [15:0] w, input int c);
        exp_t e;
        e.idx = idx[2:0];
        e.ins = w;
        e.cyc = c;
        q_main.push_back(e);
    endtask

    task automatic push_loop(input int idx, input logic [15:0] w, input int c);
        exp_t e;
        e.idx = idx[2:0];
        e.ins = w;
        e.cyc = c;
        q_loop.push_back(e);
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic begin_run(input int len, input logic m);
        prog_len = len[3:0];
        mode     = m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    logic [15:0] hi_words [8];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
        mode = 1'b0; start = 1'b0; stop = 1'b0; cpu_req = 1'b0;
        hi_words[0] = 16'h1111; hi_words[1] = 16'h0402; hi_words[2] = 16'h2803; hi_words[3] = 16'h3a03;
        hi_words[4] = 16'h4b04; hi_words[5] = 16'h5c05; hi_words[6] = 16'h6d06; hi_words[7] = 16'h7e07;
        repeat (2) tick();
        chk("reset_ins", {16'h0, m_ins}, 32'h0);
        chk("reset_en", {m_en_in, m_en_ram_out, m_busy, m_done, m_err}, 32'h0);
        chk("reset_idx", {29'h0, m_idx}, 32'h0);
        rst = 1'b0;

        // Timed run of three words, HOLD_CYCLES=4.
        write_word(0, 16'h0001);
        write_word(1, 16'h0402);
        write_word(2, 16'h2803);
        main_mon_en = 1'b1;
        t = cyc;
        push_main(0, 16'h0001, t + 1);
        push_main(1, 16'h0402, t + 5);
        push_main(2, 16'h2803, t + 9);
        begin_run(3, 1'b0);
        wait_until(t + 12);
        chk("timed_last_busy", {31'h0, m_busy}, 32'h1);
        chk("timed_last_ins", {16'h0, m_ins}, 32'h2803);
        wait_until(t + 13);
        chk("timed_done", {m_done, m_busy, m_en_in, m_en_ram_out}, 32'h8);
        chk("timed_done_ins", {13'h0, m_idx, m_ins}, {13'h0, 3'd2, 16'h2803});

        // Handshake: a 10-cycle level is one request, then two single pulses.
        t = cyc;
        push_main(0, 16'h0001, t + 1);
        begin_run(3, 1'b1);
        repeat (3) tick();
        t = cyc;
        push_main(1, 16'h0402, t + 1);
        cpu_req = 1'b1;
        repeat (10) tick();
        cpu_req = 1'b0;
        repeat (2) tick();
        chk("hs_level_one_advance", {28'h0, m_busy, m_idx}, {28'h0, 1'b1, 3'd1});
        t = cyc;
        push_main(2, 16'h2803, t + 1);
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        repeat (3) tick();
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        chk("hs_done", {m_done, m_busy, m_en_in, m_idx}, {1'b1, 1'b0, 1'b0, 3'd2});
        pulse_stop();
        chk("stop_from_done", {m_done, m_busy, l_busy, l_en_in}, 32'h0);

        // Looping instance: two words wrap 0,1,0,1 then stop.
        main_mon_en = 1'b0;
        loop_mon_en = 1'b1;
        t = cyc;
        push_loop(0, 16'h0001, t + 1);
        push_loop(1, 16'h0402, t + 5);
        push_loop(0, 16'h0001, t + 9);
        push_loop(1, 16'h0402, t + 13);
        begin_run(2, 1'b0);
        wait_until(t + 14);
        chk("loop_busy", {28'h0, l_busy, l_idx}, {28'h0, 1'b1, 3'd1});
        pulse_stop();
        chk("loop_stop_idle", {11'h0, l_busy, l_en_in, l_done, l_idx, l_ins}, 32'h0);
        loop_mon_en = 1'b0;
        main_mon_en = 1'b1;

        // Writes while busy are ignored.
        t = cyc;
        push_main(0, 16'h0001, t + 1);
        push_main(1, 16'h0402, t + 5);
        push_main(2, 16'h2803, t + 9);
        begin_run(3, 1'b0);
        write_word(1, 16'hBEEF);
        wait_until(t + 13);
        chk("busy_write_done", {31'h0, m_done}, 32'h1);
        pulse_stop();

        // prog_len=0 leaves the block idle.
        begin_run(0, 1'b0);
        chk("len0_idle", {m_busy, m_en_in, m_done}, 32'h0);
        tick();
        chk("len0_idle_later", {m_busy, m_en_ram_out, m_done}, 32'h0);

        // prog_len=9 clamps to 8 words; word 0 is written in the start cycle.
        for (int i = 3; i < 8; i++) write_word(i, hi_words[i]);
        t = cyc;
        for (int i = 0; i < 8; i++) push_main(i, hi_words[i], t + 1 + 4 * i);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1111;
        begin_run(9, 1'b0);
        wr_en = 1'b0;
        wait_until(t + 33);
        chk("clamp_done", {m_done, m_busy, m_idx}, {1'b1, 1'b0, 3'd7});
        chk("clamp_last_ins", {16'h0, m_ins}, 32'h7e07);
        pulse_stop();

        // Handshake with no requests: watchdog if present, otherwise wait forever.
        t = cyc;
        push_main(0, 16'h1111, t + 1);
        begin_run(3, 1'b1);
`ifdef STALL_TIMEOUT_EN
        wait_until(t + 15);
        chk("stall_err_before", {m_err, m_busy}, 32'h1);
        wait_until(t + 16);
        chk("stall_err_set", {31'h0, m_err}, 32'h1);
        wait_until(t + 17);
        chk("stall_done", {m_done, m_err, m_busy, m_en_in}, 32'hC);
        pulse_stop();
        chk("stall_err_cleared", {31'h0, m_err}, 32'h0);
`else
        wait_until(t + 100);
        chk("no_watchdog_busy", {m_busy, m_err, m_done}, 32'h4);
        pulse_stop();
`endif

        // Reset mid-run returns to idle but keeps the program buffer.
        t = cyc;
        push_main(0, 16'h1111, t + 1);
        push_main(1, 16'h0402, t + 5);
        begin_run(3, 1'b0);
        wait_until(t + 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_midrun", {8'h0, m_busy, m_en_in, m_done, m_err, m_idx, 1'b0, m_ins}, 32'h0);
        t = cyc;
        push_main(0, 16'h1111, t + 1);
        begin_run(1, 1'b0);
        wait_until(t + 5);
        chk("rst_keeps_mem_done", {m_done, m_busy}, 32'h2);

        repeat (2) tick();
        chk("main_queue_empty", q_main.size(), 32'h0);
        chk("loop_queue_empty", q_loop.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
